cpu_test_monitor: RTL and testbench

Synthesizable end-of-test monitor for single-core CPU benches and FPGA self-test builds. It watches the CPU's `ebreak`, `pc` and data-memory write port and decides when and how a test program has finished. It detects four completion events: a `tohost` store, `ebreak`, a PC self-loop and a cycle timeout. After a configurable drain window it raises `done` with a latched pass/fail verdict, reason code and cycle count. It generalises the fixed "stop shortly after ebreak" behaviour of the per-program benches so that every bench and the board top instantiate one block.

---
 rtl/cpu_test_monitor.sv | 139 +++++++++++++
 tb/tb_cpu_test_monitor.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_test_monitor.sv
// End-of-test monitor: watches tohost stores, ebreak, PC self-loops and a cycle
// timeout, then reports a latched verdict after a drain window.
module cpu_test_monitor #(
   parameter int unsigned CNT_W          = 32,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter int unsigned STALL_CYCLES   = 8,
   parameter int unsigned DRAIN_CYCLES   = 2,
   parameter logic [31:0] TOHOST_ADDR    = 32'h0000_0FFC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ebreak,
   input  logic [31:0]      pc,
   input  logic [31:0]      memory_address,
   input  logic [31:0]      memory_write,
   input  logic [3:0]       memory_byte_enable,
   input  logic             memory_we,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [2:0]       reason,
   output logic [30:0]      result_code,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE} state_t;
   typedef enum logic [2:0] {
      R_NONE    = 3'd0,
      R_TOHOST  = 3'd1,
      R_EBREAK  = 3'd2,
      R_LOOP    = 3'd3,
      R_TIMEOUT = 3'd4
   } reason_t;

   state_t           state_q;
   reason_t          reason_q, win_reason;
   logic             ebreak_q;
   logic [31:0]      pc_q;
   logic [31:0]      stall_q, stall_d;
   logic [31:0]      drain_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             done_q, pass_q, fail_q, verdict_q;
   logic [30:0]      result_q, win_result;
   logic             win_pass;
   logic             ev_tohost, ev_ebreak, ev_loop, ev_timeout, any_ev;

   always_comb begin
      ev_tohost  = memory_we && (memory_byte_enable == 4'hF) && (memory_address == TOHOST_ADDR);
      ev_ebreak  = ebreak && !ebreak_q;
      // stall_q counts prior equal cycles, so this cycle completes the run
      ev_loop    = (STALL_CYCLES != 0) && (pc == pc_q) && (stall_q >= STALL_CYCLES - 1);
      ev_timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

      win_reason = R_NONE;
      win_pass   = 1'b0;
      win_result = '0;
      if (ev_tohost) begin
         win_reason = R_TOHOST;
         win_pass   = (memory_write == 32'd1);
         win_result = memory_write[31:1];
      end else if (ev_ebreak) begin
         win_reason = R_EBREAK;
         win_pass   = 1'b1;
      end else if (ev_loop) begin
         win_reason = R_LOOP;
      end else if (ev_timeout) begin
         win_reason = R_TIMEOUT;
      end
      any_ev = (state_q == S_RUN) && (win_reason != R_NONE);

      if (pc != pc_q)
         stall_d = '0;
      else if (stall_q != '1)
         stall_d = stall_q + 32'd1;
      else
         stall_d = stall_q;

      cnt_d = ((state_q == S_RUN) && (cnt_q != '1)) ? cnt_q + 1'b1 : cnt_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RUN;
         reason_q  <= R_NONE;
         result_q  <= '0;
         ebreak_q  <= 1'b0;
         pc_q      <= '0;
         stall_q   <= '0;
         drain_q   <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= 1'b0;
         verdict_q <= 1'b0;
      end else begin
         ebreak_q <= ebreak;
         pc_q     <= pc;
         stall_q  <= stall_d;
         cnt_q    <= cnt_d;
         case (state_q)
            S_RUN: begin
               if (any_ev) begin
                  reason_q  <= win_reason;
                  result_q  <= win_result;
                  verdict_q <= win_pass;
                  if (DRAIN_CYCLES == 0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     pass_q  <= win_pass;
                     fail_q  <= !win_pass;
                  end else begin
                     state_q <= S_DRAIN;
                     drain_q <= DRAIN_CYCLES - 1;
                  end
               end
            end
            S_DRAIN: begin
               if (drain_q == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
                  pass_q  <= verdict_q;
                  fail_q  <= !verdict_q;
               end else begin
                  drain_q <= drain_q - 32'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign done        = done_q;
   assign pass        = pass_q;
   assign fail        = fail_q;
   assign reason      = reason_q;
   assign result_code = result_q;
   assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Directed bench for cpu_test_monitor: drain-2 instance plus a drain-0 instance
// sharing the same stimulus.
module tb_cpu_test_monitor;

   logic        clk;
   logic        rst_n;
   logic        ebreak;
   logic [31:0] pc;
   logic [31:0] memory_address;
   logic [31:0] memory_write;
   logic [3:0]  memory_byte_enable;
   logic        memory_we;

   logic        done, pass, fail;
   logic [2:0]  reason;
   logic [30:0] result_code;
   logic [31:0] cycle_count;

   logic        done0, pass0, fail0;
   logic [2:0]  reason0;
   logic [30:0] result_code0;
   logic [31:0] cycle_count0;

   int n_cmp = 0;
   int n_err = 0;

   cpu_test_monitor #(
      .CNT_W(32), .TIMEOUT_CYCLES(50), .STALL_CYCLES(8), .DRAIN_CYCLES(2),
      .TOHOST_ADDR(32'h0000_0FFC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ebreak(ebreak), .pc(pc),
      .memory_address(memory_address), .memory_write(memory_write),
      .memory_byte_enable(memory_byte_enable), .memory_we(memory_we),
      .done(done), .pass(pass), .fail(fail), .reason(reason),
      .result_code(result_code), .cycle_count(cycle_count)
   );

   cpu_test_monitor #(
      .CNT_W(32), .TIMEOUT_CYCLES(50), .STALL_CYCLES(8), .DRAIN_CYCLES(0),
      .TOHOST_ADDR(32'h0000_0FFC)
   ) dut0 (
      .clk(clk), .rst_n(rst_n), .ebreak(ebreak), .pc(pc),
      .memory_address(memory_address), .memory_write(memory_write),
      .memory_byte_enable(memory_byte_enable), .memory_we(memory_we),
      .done(done0), .pass(pass0), .fail(fail0), .reason(reason0),
      .result_code(result_code0), .cycle_count(cycle_count0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         pc = pc + 32'd4;
         tick();
      end
   endtask

   task automatic clear_store();
      memory_we          = 1'b0;
      memory_address     = '0;
      memory_write       = '0;
      memory_byte_enable = '0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      memory_we          = 1'b1;
      memory_address     = a;
      memory_write       = d;
      memory_byte_enable = be;
   endtask

   // Leaves rst_n released just after an edge, so the next posedge is edge 0.
   task automatic do_reset();
      rst_n  = 1'b0;
      ebreak = 1'b0;
      pc     = 32'h100;
      clear_store();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      do_reset();
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_fail", fail, 0);
      chk("rst_reason", reason, 0);
      chk("rst_result", result_code, 0);
      chk("rst_count", cycle_count, 0);

      // tohost pass at edge 40
      idle(40);
      chk("t1_pre_reason", reason, 0);
      chk("t1_pre_count", cycle_count, 40);
      store(32'hFFC, 32'd1, 4'hF);
      pc = pc + 32'd4;
      tick();
      chk("t1_reason", reason, 1);
      chk("t1_done_early", done, 0);
      chk("t1_count", cycle_count, 41);
      chk("t1_d0_done", done0, 1);
      chk("t1_d0_pass", pass0, 1);
      chk("t1_d0_reason", reason0, 1);
      clear_store();
      ebreak = 1'b1;
      pc = pc + 32'd4;
      tick();
      chk("t1_drain_ebreak_reason", reason, 1);
      chk("t1_drain_done", done, 0);
      ebreak = 1'b0;
      idle(1);
      chk("t1_done", done, 1);
      chk("t1_pass", pass, 1);
      chk("t1_fail", fail, 0);
      chk("t1_result", result_code, 0);
      chk("t1_count_frozen", cycle_count, 41);
      idle(3);
      chk("t1_done_sticky", done, 1);
      chk("t1_d0_reason_held", reason0, 1);

      // partial store ignored, then word store of 7 fails
      do_reset();
      idle(3);
      store(32'hFFC, 32'd1, 4'h1);
      pc = pc + 32'd4;
      tick();
      chk("t2_byte_reason", reason, 0);
      chk("t2_byte_d0_done", done0, 0);
      clear_store();
      idle(1);
      store(32'hFFC, 32'h7, 4'hF);
      pc = pc + 32'd4;
      tick();
      chk("t2_reason", reason, 1);
      chk("t2_result", result_code, 3);
      chk("t2_d0_fail", fail0, 1);
      chk("t2_d0_pass", pass0, 0);
      clear_store();
      idle(2);
      chk("t2_done", done, 1);
      chk("t2_fail", fail, 1);
      chk("t2_pass", pass, 0);
      chk("t2_count", cycle_count, 6);

      // ebreak held 5 cycles from edge 10; tohost store during DRAIN ignored
      do_reset();
      idle(10);
      ebreak = 1'b1;
      pc = pc + 32'd4;
      tick();
      chk("t3_reason", reason, 2);
      chk("t3_count", cycle_count, 11);
      store(32'hFFC, 32'h7, 4'hF);
      pc = pc + 32'd4;
      tick();
      chk("t3_drain_reason", reason, 2);
      chk("t3_drain_result", result_code, 0);
      clear_store();
      idle(1);
      chk("t3_done", done, 1);
      chk("t3_pass", pass, 1);
      chk("t3_fail", fail, 0);
      idle(2);
      ebreak = 1'b0;
      idle(2);
      chk("t3_reason_held", reason, 2);
      chk("t3_count_frozen", cycle_count, 11);

      // pc stuck at 0x40: self-loop completes at edge 8
      do_reset();
      pc = 32'h40;
      for (int i = 0; i < 8; i++) tick();
      chk("t4_pre_reason", reason, 0);
      tick();
      chk("t4_reason", reason, 3);
      chk("t4_count", cycle_count, 9);
      chk("t4_d0_fail", fail0, 1);
      tick();
      tick();
      chk("t4_done", done, 1);
      chk("t4_fail", fail, 1);
      chk("t4_pass", pass, 0);

      // pc toggling: no self-loop, timeout at edge 49
      do_reset();
      for (int k = 0; k < 49; k++) begin
         pc = (k % 2 == 1) ? 32'h44 : 32'h40;
         tick();
      end
      chk("t5_pre_reason", reason, 0);
      chk("t5_pre_count", cycle_count, 49);
      pc = 32'h44;
      tick();
      chk("t5_reason", reason, 4);
      chk("t5_count", cycle_count, 50);
      pc = 32'h40;
      tick();
      pc = 32'h44;
      tick();
      chk("t5_done", done, 1);
      chk("t5_fail", fail, 1);
      chk("t5_result", result_code, 0);
      chk("t5_count_frozen", cycle_count, 50);

      // tohost and ebreak together, then reset mid-DRAIN and rerun
      do_reset();
      idle(6);
      store(32'hFFC, 32'd1, 4'hF);
      ebreak = 1'b1;
      pc = pc + 32'd4;
      tick();
      chk("t6_prio_reason", reason, 1);
      chk("t6_d0_done", done0, 1);
      clear_store();
      ebreak = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_reason", reason, 0);
      chk("t6_async_count", cycle_count, 0);
      chk("t6_async_d0_done", done0, 0);
      chk("t6_async_d0_pass", pass0, 0);
      do_reset();
      idle(3);
      ebreak = 1'b1;
      pc = pc + 32'd4;
      tick();
      chk("t6_rerun_reason", reason, 2);
      ebreak = 1'b0;
      idle(2);
      chk("t6_rerun_done", done, 1);
      chk("t6_rerun_pass", pass, 1);
      chk("t6_rerun_count", cycle_count, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
